fir_filter: RTL and testbench

- Time-multiplexed N-tap FIR filter for the 10-bit voltage samples delivered by the SPI receive stage.
- Sits directly downstream of that stage and upstream of the `filtered` output of `signal_processing`.
- Accepts one sample per handshake, shifts it into a delay line, and runs one multiply-accumulate per tap on a single shared multiplier.
- Emits a saturated 10-bit result with a one-cycle valid strobe.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_filter_if.sv | 28 ++
 rtl/fir_mac.sv | 35 +++
 rtl/fir_filter.sv | 82 ++++++++
 tb/tb_fir_filter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants, types and saturation helper for the
// time-multiplexed FIR filter.
package fir_pkg;

    localparam int NTAPS = 3;
    localparam int DW    = 10;
    localparam int CW    = 10;
    localparam int QSH   = 9;
    localparam int PW    = DW + 1 + CW;
    localparam int ACCW  = PW + $clog2(NTAPS);
    localparam int IW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

    typedef logic signed [PW-1:0]   prod_t;
    typedef logic signed [ACCW-1:0] acc_t;

    // Floor via arithmetic shift, then clamp to the unsigned range.
    function automatic logic [DW-1:0] sat(input acc_t v);
        acc_t sh;
        sh = v >>> QSH;
        if (sh < 0)
            return '0;
        else if (sh > acc_t'((2 ** DW) - 1))
            return '1;
        else
            return sh[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_filter_if.sv
// Sample-in / result-out stream between the SPI receive
// stage, the FIR filter and the signal processing output.
interface fir_filter_if;
    import fir_pkg::*;

    logic          sample_valid;
    logic          sample_ready;
    logic [DW-1:0] voltage;
    logic [DW-1:0] filtered;
    logic          filtered_valid;

    modport master (
        output sample_valid,
        output voltage,
        input  sample_ready,
        input  filtered,
        input  filtered_valid
    );

    modport slave (
        input  sample_valid,
        input  voltage,
        output sample_ready,
        output filtered,
        output filtered_valid
    );

endinterface

// File: rtl/fir_mac.sv
// Two-stage multiply-accumulate: registered product, then
// accumulate, so the last tap lands one cycle after issue.
module fir_mac
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DW-1:0]        x,
    input  logic signed [CW-1:0] c,
    output acc_t                 acc
);

    prod_t prod;
    logic  prod_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else if (clr) begin
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod_v <= en;
            if (en)
                prod <= prod_t'($signed({1'b0, x})) * prod_t'(c);
            if (prod_v)
                acc <= acc + acc_t'(prod);
        end
    end

endmodule

// File: rtl/fir_filter.sv
// N-tap FIR controller: delay line, coefficient latch,
// tap sequencing, saturation and overrun flag.
module fir_filter
    import fir_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    fir_filter_if.slave        s,
    input  logic [NTAPS*CW-1:0] a,
    output logic               overrun
);

    fir_state_t           state;
    logic [IW-1:0]        idx;
    logic [DW-1:0]        x    [NTAPS];
    logic signed [CW-1:0] coef [NTAPS];
    logic                 done;
    logic                 accept;
    logic                 en;
    acc_t                 acc;

    assign s.sample_ready = (state == IDLE);
    assign accept         = s.sample_valid && s.sample_ready;
    assign en             = (state == MAC);

    fir_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (en),
        .x       (x[idx]),
        .c       (coef[idx]),
        .acc     (acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            done             <= 1'b0;
            overrun          <= 1'b0;
            s.filtered       <= '0;
            s.filtered_valid <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x[k]    <= '0;
                coef[k] <= '0;
            end
        end else begin
            s.filtered_valid <= done;
            done             <= 1'b0;
            // acc holds the full sum one cycle after OUT
            if (done)
                s.filtered <= sat(acc);
            if (s.sample_valid && !s.sample_ready)
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x[0] <= s.voltage;
                        for (int k = 1; k < NTAPS; k++)
                            x[k] <= x[k-1];
                        for (int k = 0; k < NTAPS; k++)
                            coef[k] <= a[k*CW +: CW];
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    idx <= idx + 1'b1;
                    if (idx == IW'(NTAPS - 1))
                        state <= OUT;
                end
                OUT: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: directed plan plus random samples
// checked against an arithmetic reference model.
module tb_fir_filter;

    logic        clk;
    logic        reset_n;
    logic [29:0] a;
    logic        overrun;
    int          errors;
    int          checks;
    int          hist [3];

    fir_filter_if bus ();

    fir_filter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (bus.slave),
        .a       (a),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] pack3(input int t2, input int t1, input int t0);
        logic [9:0] c2, c1, c0;
        c2 = 10'(t2);
        c1 = 10'(t1);
        c0 = 10'(t0);
        return {c2, c1, c0};
    endfunction

    // y = clamp(floor(sum(x[k]*a[k]) / 512), 0, 1023)
    function automatic int model(input int v, input logic [29:0] av);
        logic signed [9:0] t;
        int sum, q, cf;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = v;
        sum = 0;
        for (int k = 0; k < 3; k++) begin
            t   = av[k*10 +: 10];
            cf  = t;
            sum = sum + hist[k] * cf;
        end
        q = sum / 512;
        if (sum < 0 && q * 512 != sum)
            q = q - 1;
        if (q < 0)
            return 0;
        if (q > 1023)
            return 1023;
        return q;
    endfunction

    task automatic send(input logic [9:0] v, input logic [29:0] av,
                        input int gk, input bit chg, output int got);
        int expv, lat, nstb, w;
        got = -1;
        a   = av;
        w   = 0;
        while (!bus.sample_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: ready=%b required 1", bus.sample_ready);
        end
        bus.sample_valid = 1'b1;
        bus.voltage      = v;
        @(posedge clk);
        expv = model(int'(v), av);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        lat  = -1;
        nstb = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.sample_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: ready=%b required 0", bus.sample_ready);
                end
                if (chg)
                    a = 30'($urandom);
            end
            if (k == 4) begin
                checks++;
                if (bus.sample_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_return: ready=%b required 1", bus.sample_ready);
                end
            end
            if (bus.filtered_valid === 1'b1) begin
                nstb++;
                if (lat < 0) begin
                    lat = k;
                    got = int'(bus.filtered);
                end
            end
            if (k == gk) begin
                bus.sample_valid = 1'b1;
                bus.voltage      = 10'd777;
            end else if (k == gk + 1) begin
                bus.sample_valid = 1'b0;
            end
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 5", lat);
        end
        checks++;
        if (nstb != 1) begin
            errors++;
            $display("FAIL strobe_count: got %0d required 1", nstb);
        end
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL result: in=%0d got %0d required %0d", v, got, expv);
        end
    endtask

    task automatic expect_val(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic test_reset;
        reset_n          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.voltage      = '0;
        a                = '0;
        for (int k = 0; k < 3; k++) hist[k] = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_val("reset_filtered", int'(bus.filtered), 0);
        expect_val("reset_valid", int'(bus.filtered_valid), 0);
        expect_val("reset_overrun", int'(overrun), 0);
        expect_val("reset_ready", int'(bus.sample_ready), 1);
    endtask

    task automatic test_impulse;
        logic [29:0] av;
        int got;
        int req [4] = '{511, 255, 127, 0};
        av = pack3(64, 128, 256);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 10'd1023 : 10'd0, av, -1, 1'b0, got);
            expect_val("impulse", got, req[i]);
        end
    endtask

    task automatic test_dc;
        logic [29:0] av;
        int got;
        av = pack3(171, 170, 171);
        for (int i = 0; i < 5; i++) begin
            send(10'd600, av, -1, 1'b0, got);
            expect_val("dc_gain", got, (i == 0) ? 200 : (i == 1) ? 399 : 600);
        end
    endtask

    task automatic test_saturation;
        int got;
        for (int i = 0; i < 3; i++)
            send(10'd1023, pack3(511, 511, 511), -1, 1'b0, got);
        expect_val("sat_high", got, 1023);
        send(10'd1000, pack3(-256, -256, -256), -1, 1'b0, got);
        expect_val("sat_low", got, 0);
    endtask

    task automatic test_overrun;
        logic [29:0] av;
        int got;
        av = pack3(64, 128, 256);
        for (int i = 0; i < 3; i++)
            send(10'd0, av, -1, 1'b0, got);
        expect_val("overrun_clear", int'(overrun), 0);
        send(10'd1023, av, 2, 1'b0, got);
        expect_val("overrun_first", got, 511);
        expect_val("overrun_set", int'(overrun), 1);
        send(10'd0, av, -1, 1'b0, got);
        expect_val("overrun_history", got, 255);
        expect_val("overrun_sticky", int'(overrun), 1);
    endtask

    task automatic test_reset_mid;
        int got, nstb;
        a = pack3(64, 128, 256);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.voltage      = 10'd900;
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        expect_val("midrst_filtered", int'(bus.filtered), 0);
        expect_val("midrst_overrun", int'(overrun), 0);
        expect_val("midrst_ready", int'(bus.sample_ready), 1);
        nstb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) reset_n = 1'b1;
            if (bus.filtered_valid !== 1'b0) nstb++;
        end
        expect_val("midrst_no_strobe", nstb, 0);
        for (int k = 0; k < 3; k++) hist[k] = 0;
        send(10'd1023, pack3(64, 128, 256), -1, 1'b0, got);
        expect_val("midrst_impulse", got, 511);
    endtask

    task automatic test_random;
        int got;
        for (int i = 0; i < 20; i++)
            send(10'($urandom_range(0, 1023)), 30'($urandom), -1, 1'b1, got);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
